// File: rtl/dft_pkg.sv
// Shared types and defaults for the direct-DFT sequencer.
package dft_pkg;

  localparam int unsigned DFT_AW      = 12;
  localparam int unsigned DFT_MAX_N   = 4096;
  // Deepest supported accumulator delay line (PIPE_LAT upper bound)
  localparam int unsigned ACC_DLY_MAX = 7;
  localparam int unsigned DRAIN_W     = $clog2(ACC_DLY_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_LOAD,
    S_ISSUE,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } seq_state_t;

  // One stage of the accumulator-control delay line
  typedef struct packed {
    logic en;
    logic first;
  } acc_tap_t;

endpackage

// File: rtl/dft_mod_step.sv
// Modular twiddle step: (tw + k) mod n, for tw, k < n, without a multiplier.
module dft_mod_step
  import dft_pkg::*;
#(
  parameter int unsigned AW = DFT_AW
) (
  input  logic [AW-1:0] tw_i,
  input  logic [AW-1:0] k_i,
  input  logic [AW-1:0] n_i,
  output logic [AW-1:0] step_c_o
);

  logic [AW:0] sum_c;

  // One conditional subtract suffices since tw + k < 2n
  always_comb begin
    sum_c = {1'b0, tw_i} + {1'b0, k_i};
    if (sum_c >= {1'b0, n_i}) begin
      sum_c = sum_c - {1'b0, n_i};
    end
    step_c_o = sum_c[AW-1:0];
  end

endmodule

// File: rtl/dft_sequencer.sv
// Direct-DFT sequencer: sweeps n for every bin k, drives reads, twiddle
// index, accumulator control and one result write per bin.
module dft_sequencer
  import dft_pkg::*;
#(
  parameter int unsigned AW       = DFT_AW,
  parameter int unsigned MAX_N    = DFT_MAX_N,
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] samp_number,
  input  logic          data_loaded,
  output logic          load_nCompute,
  output logic          busy,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic [AW-1:0] tw_idx,
  output logic          acc_en,
  output logic          acc_first,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic          calc_end,
  output logic          err
);

  seq_state_t         state_q;
  logic [AW-1:0]      n_q, k_q, tw_q, nlen_q;
  logic [AW-1:0]      tw_d;
  logic [DRAIN_W-1:0] drain_q;
  logic               rd_en_q, wr_en_q, calc_end_q, err_q, busy_q, load_q;
  acc_tap_t           dly_q [PIPE_LAT];

  logic samp_ok_c, last_n_c, last_k_c;

  assign samp_ok_c = (samp_number >= AW'(2)) && (32'(samp_number) <= MAX_N);
  assign last_n_c  = (n_q == nlen_q - AW'(1));
  assign last_k_c  = (k_q == nlen_q - AW'(1));

  dft_mod_step #(.AW(AW)) u_step (
    .tw_i     (tw_q),
    .k_i      (k_q),
    .n_i      (nlen_q),
    .step_c_o (tw_d)
  );

  // Sequencer state, sweep counters and registered strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      k_q        <= '0;
      tw_q       <= '0;
      nlen_q     <= '0;
      drain_q    <= '0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      calc_end_q <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      load_q     <= 1'b1;
    end else begin
      wr_en_q    <= 1'b0;
      calc_end_q <= 1'b0;
      err_q      <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (samp_ok_c) begin
              nlen_q  <= samp_number;
              busy_q  <= 1'b1;
              state_q <= S_WAIT_LOAD;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_WAIT_LOAD: begin
          if (data_loaded) begin
            state_q <= S_ISSUE;
            k_q     <= '0;
            n_q     <= '0;
            tw_q    <= '0;
            rd_en_q <= 1'b1;
            load_q  <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (last_n_c) begin
            state_q <= S_DRAIN;
            rd_en_q <= 1'b0;
            drain_q <= '0;
          end else begin
            n_q  <= n_q + AW'(1);
            tw_q <= tw_d;
          end
        end
        S_DRAIN: begin
          if (drain_q == DRAIN_W'(PIPE_LAT - 1)) begin
            state_q <= S_WRITE;
            wr_en_q <= 1'b1;
          end else begin
            drain_q <= drain_q + DRAIN_W'(1);
          end
        end
        S_WRITE: begin
          if (last_k_c) begin
            state_q    <= S_DONE;
            calc_end_q <= 1'b1;
            load_q     <= 1'b1;
          end else begin
            state_q <= S_ISSUE;
            k_q     <= k_q + AW'(1);
            n_q     <= '0;
            tw_q    <= '0;
            rd_en_q <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Accumulator controls trail the read strobe by exactly PIPE_LAT cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(PIPE_LAT); i++) dly_q[i] <= '0;
    end else begin
      dly_q[0] <= '{en: rd_en_q, first: rd_en_q && (n_q == '0)};
      for (int i = 1; i < int'(PIPE_LAT); i++) dly_q[i] <= dly_q[i-1];
    end
  end

  assign load_nCompute = load_q;
  assign busy          = busy_q;
  assign rd_en         = rd_en_q;
  assign rd_addr       = n_q;
  assign tw_idx        = tw_q;
  assign acc_en        = dly_q[PIPE_LAT-1].en;
  assign acc_first     = dly_q[PIPE_LAT-1].first;
  assign wr_en         = wr_en_q;
  assign wr_addr       = k_q;
  assign calc_end      = calc_end_q;
  assign err           = err_q;

endmodule
